aidc_lite_comp_sel: RTL and testbench

- Sits between the three compressors (SR, ZRLE, BPC) with their result buffers, and the compression engine's read-back port (comp_ready/comp_rden/comp_rdata).
- Per 128 B block, tracks each compressor's output size and done/fail status, then picks the smallest successful encoding.
- Drives a shared read address to all result buffers and serialises the selected buffer's 64-bit words into 32-bit words for the engine.
- Falls back to RAW when no compressor saves space.

---
 rtl/aidc_lite_comp_pkg.sv | 26 ++
 rtl/aidc_lite_comp_size_min.sv | 29 ++
 rtl/aidc_lite_comp_sel.sv | 188 ++++++++++++++++++
 tb/tb_aidc_lite_comp_sel.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aidc_lite_comp_pkg.sv
// Shared types and constants for the compressor result selector.
// Selection and FSM state enums, result-buffer geometry.
package aidc_lite_comp_pkg;

    localparam int NUM_COMP  = 3;
    localparam int BUF_DEPTH = 16;
    localparam int RAW_SIZE  = 16;
    localparam int SZ_W      = $clog2(BUF_DEPTH) + 1;

    typedef enum logic [1:0] {
        SEL_SR,
        SEL_ZRLE,
        SEL_BPC,
        SEL_RAW
    } sel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DECIDE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/aidc_lite_comp_size_min.sv
// Combinational 3-way minimum over eligible compressor sizes.
// Ports: size_i/fail_i per compressor -> ok_o, sel_o, size_o (lowest index wins ties).
module aidc_lite_comp_size_min
    import aidc_lite_comp_pkg::*;
(
    input  logic [NUM_COMP-1:0][SZ_W-1:0] size_i,
    input  logic [NUM_COMP-1:0]           fail_i,
    output logic                          ok_o,
    output sel_t                          sel_o,
    output logic [SZ_W-1:0]               size_o
);

    always_comb begin
        ok_o   = 1'b0;
        sel_o  = SEL_RAW;
        size_o = SZ_W'(RAW_SIZE);
        for (int n = 0; n < NUM_COMP; n++) begin
            // strict '<' keeps the earlier index on a tie
            if (!fail_i[n] && size_i[n] != '0 &&
                size_i[n] < SZ_W'(RAW_SIZE) &&
                (!ok_o || size_i[n] < size_o)) begin
                ok_o   = 1'b1;
                sel_o  = sel_t'(2'(n));
                size_o = size_i[n];
            end
        end
    end

endmodule

// File: rtl/aidc_lite_comp_sel.sv
// Picks the smallest successful compressor output per block and streams it
// as 32-bit words. Ports: compressor write/done/fail in, shared buffer read
// address/data, engine ready/rden/rdata, sel/size/done out.
// Optional macro AIDC_LITE_COMP_SEL_HDR_EN prepends a {sel,size} header word.
module aidc_lite_comp_sel
    import aidc_lite_comp_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int ADDR_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sop_i,
    input  logic [NUM_COMP-1:0]          comp_wren_i,
    input  logic [NUM_COMP*ADDR_W-1:0]   comp_waddr_i,
    input  logic [NUM_COMP-1:0]          comp_done_i,
    input  logic [NUM_COMP-1:0]          comp_fail_i,
    output logic [ADDR_W-1:0]            buf_raddr_o,
    input  logic [NUM_COMP*64-1:0]       buf_rdata_i,
    output logic                         ready_o,
    input  logic                         rden_i,
    output logic [31:0]                  rdata_o,
    output logic [1:0]                   sel_o,
    output logic [SZ_W-1:0]              size_o,
    output logic                         done_o
);

`ifdef AIDC_LITE_COMP_SEL_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    state_t                        state_q, state_d;
    logic [NUM_COMP-1:0]           done_q, fail_q, done_nx, fail_nx;
    logic [NUM_COMP-1:0][SZ_W-1:0] size_q, size_nx, wend;
    logic [CNT_W-1:0]              cnt_q;
    logic                          tmo, all_done;
    sel_t                          sel_q, min_sel;
    logic [SZ_W-1:0]               sel_size_q, min_size;
    logic                          min_ok;
    logic [ADDR_W-1:0]             raddr_q, idx_q;
    logic [63:0]                   hold_q, slice;
    logic                          half_q, hdr_q, ready_q, last_word;

    // Status including this cycle's strobes, so a done seen in the last
    // COLLECT cycle still counts toward the exit and the decision.
    always_comb begin
        done_nx = done_q | comp_done_i;
        fail_nx = fail_q | (comp_fail_i & comp_done_i);
        size_nx = size_q;
        for (int n = 0; n < NUM_COMP; n++) begin
            wend[n] = SZ_W'(comp_waddr_i[n*ADDR_W +: ADDR_W]) + SZ_W'(1);
            if (comp_wren_i[n] && wend[n] > size_nx[n])
                size_nx[n] = wend[n];
        end
    end

    assign all_done  = &done_nx;
    assign tmo       = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign last_word = (SZ_W'(idx_q) == sel_size_q - SZ_W'(1));

    aidc_lite_comp_size_min u_min (
        .size_i (size_q),
        .fail_i (fail_q),
        .ok_o   (min_ok),
        .sel_o  (min_sel),
        .size_o (min_size)
    );

    always_comb begin
        slice = '0;
        unique case (sel_q)
            SEL_SR:   slice = buf_rdata_i[63:0];
            SEL_ZRLE: slice = buf_rdata_i[127:64];
            SEL_BPC:  slice = buf_rdata_i[191:128];
            default:  slice = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (sop_i) begin
            state_d = ST_COLLECT;
        end else begin
            unique case (state_q)
                ST_IDLE:    state_d = ST_IDLE;
                ST_COLLECT: if (all_done || tmo) state_d = ST_DECIDE;
                ST_DECIDE:  state_d = min_ok ? ST_FETCH : ST_DONE;
                ST_FETCH:   state_d = ST_DRAIN;
                ST_DRAIN:   if (rden_i && !hdr_q && half_q && last_word)
                                state_d = ST_DONE;
                ST_DONE:    state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        done_o  = (state_q == ST_DONE);
        rdata_o = '0;
        if (state_q == ST_DRAIN) begin
            if (hdr_q)       rdata_o = {24'h0, 1'b0, sel_q, sel_size_q};
            else if (half_q) rdata_o = hold_q[63:32];
            else             rdata_o = hold_q[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q     <= '0;
            fail_q     <= '0;
            size_q     <= '0;
            cnt_q      <= '0;
            sel_q      <= SEL_RAW;
            sel_size_q <= SZ_W'(RAW_SIZE);
            raddr_q    <= '0;
            idx_q      <= '0;
            hold_q     <= '0;
            half_q     <= 1'b0;
            hdr_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else if (sop_i) begin
            done_q  <= '0;
            fail_q  <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_COLLECT: begin
                    done_q <= done_nx;
                    fail_q <= fail_nx | (tmo ? ~done_nx : '0);
                    size_q <= size_nx;
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                ST_DECIDE: begin
                    raddr_q <= '0;
                    idx_q   <= '0;
                    if (min_ok) begin
                        sel_q      <= min_sel;
                        sel_size_q <= min_size;
                    end else begin
                        sel_q      <= SEL_RAW;
                        sel_size_q <= SZ_W'(RAW_SIZE);
                    end
                end
                ST_FETCH: begin
                    hold_q  <= slice;
                    half_q  <= 1'b0;
                    hdr_q   <= HDR_EN;
                    ready_q <= 1'b1;
                end
                ST_DRAIN: begin
                    if (rden_i) begin
                        if (hdr_q) begin
                            hdr_q <= 1'b0;
                        end else if (!half_q) begin
                            half_q <= 1'b1;
                            // prefetch next word; never past size-1
                            if (!last_word) raddr_q <= idx_q + ADDR_W'(1);
                        end else if (last_word) begin
                            ready_q <= 1'b0;
                        end else begin
                            hold_q <= slice;
                            half_q <= 1'b0;
                            idx_q  <= idx_q + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign buf_raddr_o = raddr_q;
    assign ready_o     = ready_q;
    assign sel_o       = sel_q;
    assign size_o      = sel_size_q;

endmodule

// File: tb/tb_aidc_lite_comp_sel.sv
// Randomised bench for aidc_lite_comp_sel against a block-level reference.
// Honours AIDC_LITE_COMP_SEL_HDR_EN for the optional header word.
module tb_aidc_lite_comp_sel;
    import aidc_lite_comp_pkg::*;

    localparam int ADDR_W = 4;
    localparam int TMO    = 64;

`ifdef AIDC_LITE_COMP_SEL_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              sop   = 1'b0;
    logic              rden  = 1'b0;
    logic [2:0]        wren  = '0;
    logic [2:0]        cdone = '0;
    logic [2:0]        cfail = '0;
    logic [3*ADDR_W-1:0] waddr = '0;
    logic [ADDR_W-1:0] raddr;
    logic [191:0]      bdata;
    logic              ready;
    logic [31:0]       rdata;
    logic [1:0]        sel;
    logic [4:0]        size;
    logic              done;
    logic [63:0]       mem [3][16];
    int                n_chk = 0;
    int                n_fail = 0;

    always #5 clk = ~clk;

    // Result buffers: read data follows the registered address
    assign bdata = {mem[2][raddr], mem[1][raddr], mem[0][raddr]};

    aidc_lite_comp_sel #(.TIMEOUT_CYC(TMO), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sop_i        (sop),
        .comp_wren_i  (wren),
        .comp_waddr_i (waddr),
        .comp_done_i  (cdone),
        .comp_fail_i  (cfail),
        .buf_raddr_o  (raddr),
        .buf_rdata_i  (bdata),
        .ready_o      (ready),
        .rden_i       (rden),
        .rdata_o      (rdata),
        .sel_o        (sel),
        .size_o       (size),
        .done_o       (done)
    );

    task automatic do_block(input string nm, input int s0, input int s1,
                            input int s2, input logic [2:0] f,
                            input logic [2:0] nd, input bit hold_hi,
                            input bit gaps, input int abort_at,
                            input bit abort_rd);
        int sz[3];
        int dly[3];
        int exp_sel, exp_size, e_edge, tgt, k, guard, maxd;
        bit raw, aborted, g;
        logic [31:0] ew[$];
        sz[0] = s0; sz[1] = s1; sz[2] = s2;
        for (int n = 0; n < 3; n++) begin
            dly[n] = int'($urandom_range(0, 3));
            for (int a = 0; a < 16; a++) mem[n][a] = {$urandom, $urandom};
        end
        // Reference: smallest non-failed size in 1..15, earliest index on tie
        exp_sel = 3; exp_size = 16;
        for (int n = 0; n < 3; n++)
            if (!nd[n] && !f[n] && sz[n] > 0 && sz[n] < exp_size) begin
                exp_sel = n; exp_size = sz[n];
            end
        raw = (exp_sel == 3);
        maxd = 0;
        for (int n = 0; n < 3; n++) if (!nd[n] && dly[n] > maxd) maxd = dly[n];
        e_edge = (nd != 3'b000) ? TMO : 18 + maxd;
        tgt = raw ? e_edge + 2 : e_edge + 3;
        if (HDR && !raw) ew.push_back({24'h0, 1'b0, 2'(exp_sel), 5'(exp_size)});
        if (!raw)
            for (int w = 0; w < exp_size; w++) begin
                ew.push_back(mem[exp_sel][w][31:0]);
                ew.push_back(mem[exp_sel][w][63:32]);
            end

        @(negedge clk);
        sop = 1'b1; rden = hold_hi; wren = '0; cdone = '0; cfail = '0;
        for (int t = 1; t <= tgt; t++) begin
            @(negedge clk);
            if (t < tgt) begin
                n_chk++;
                if (ready !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s early_out t=%0d: ready=%b done=%b, required 0 0",
                             nm, t, ready, done);
                end
            end
            sop = 1'b0; wren = '0; cdone = '0; cfail = 3'($urandom);
            for (int n = 0; n < 3; n++) begin
                if (t <= 16 && t - 1 < sz[n]) begin
                    wren[n] = 1'b1;
                    waddr[n*ADDR_W +: ADDR_W] = ADDR_W'(t - 1);
                end
                if (t == 17 && sz[n] > 0) begin
                    wren[n] = 1'b1;
                    waddr[n*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, sz[n] - 1));
                end
                if (!nd[n] && t == 18 + dly[n]) begin
                    cdone[n] = 1'b1;
                    cfail[n] = f[n];
                end
            end
        end
        cfail = '0;

        n_chk++;
        if (sel !== 2'(exp_sel)) begin
            n_fail++;
            $display("FAIL %s sel: got %0d, required %0d", nm, sel, exp_sel);
        end
        n_chk++;
        if (size !== 5'(exp_size)) begin
            n_fail++;
            $display("FAIL %s size: got %0d, required %0d", nm, size, exp_size);
        end

        if (raw) begin
            n_chk++;
            if (done !== 1'b1 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s raw_done: done=%b ready=%b, required 1 0", nm, done, ready);
            end
            rden = 1'b0;
            @(negedge clk);
            n_chk++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_pulse: done=%b, required 0", nm, done);
            end
            return;
        end

        k = 0; guard = 0; aborted = 1'b0;
        while (k < ew.size() && !aborted && guard < 300) begin
            guard++;
            if (k == abort_at) begin
                sop = 1'b1; rden = abort_rd; aborted = 1'b1;
            end else begin
                g = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                rden = g;
                n_chk++;
                if (ready !== 1'b1 || rdata !== ew[k]) begin
                    n_fail++;
                    $display("FAIL %s word%0d: ready=%b rdata=%h, required 1 %h",
                             nm, k, ready, rdata, ew[k]);
                end
                n_chk++;
                if (int'(raddr) >= exp_size) begin
                    n_fail++;
                    $display("FAIL %s raddr: got %0d, required < %0d", nm, raddr, exp_size);
                end
                if (g) k++;
            end
            @(negedge clk);
        end
        if (guard >= 300) begin
            n_chk++; n_fail++;
            $display("FAIL %s drain_budget: consumed %0d, required %0d", nm, k, ew.size());
        end

        sop = 1'b0; rden = 1'b0;
        if (aborted) begin
            n_chk++;
            if (ready !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s abort: ready=%b done=%b, required 0 0", nm, ready, done);
            end
            repeat (3) begin
                @(negedge clk);
                n_chk++;
                if (done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s abort_nodone: done=%b, required 0", nm, done);
                end
            end
        end else begin
            n_chk++;
            if (done !== 1'b1 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s end: done=%b ready=%b, required 1 0", nm, done, ready);
            end
            @(negedge clk);
            n_chk++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_pulse: done=%b, required 0", nm, done);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (ready !== 1'b0 || done !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out: ready=%b done=%b rdata=%h, required 0 0 0",
                     ready, done, rdata);
        end
        n_chk++;
        if (raddr !== 4'd0 || sel !== 2'd3 || size !== 5'd16) begin
            n_fail++;
            $display("FAIL reset_sel: raddr=%0d sel=%0d size=%0d, required 0 3 16",
                     raddr, sel, size);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zrle_pick();
        do_block("zrle_pick", 5, 3, 2, 3'b100, 3'b000, 1'b1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_all_fail();
        do_block("all_fail", 5, 3, 2, 3'b111, 3'b000, 1'b0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_tie();
        do_block("tie", 4, 16, 4, 3'b000, 3'b000, 1'b0, 1'b1, -1, 1'b0);
    endtask

    task automatic test_timeout();
        do_block("timeout", 6, 5, 2, 3'b000, 3'b100, 1'b0, 1'b1, -1, 1'b0);
    endtask

    task automatic test_abort();
        do_block("abort", 5, 3, 2, 3'b100, 3'b000, 1'b0, 1'b0, 2, 1'b1);
        do_block("after_abort", 7, 9, 1, 3'b000, 3'b000, 1'b0, 1'b1, -1, 1'b0);
        do_block("abort_last", 5, 3, 2, 3'b100, 3'b000, 1'b0, 1'b0,
                 HDR ? 6 : 5, 1'b1);
        do_block("after_last", 2, 8, 8, 3'b001, 3'b000, 1'b0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_bounds();
        do_block("full15", 16, 16, 15, 3'b000, 3'b000, 1'b0, 1'b1, -1, 1'b0);
        do_block("all16", 16, 16, 16, 3'b000, 3'b000, 1'b0, 1'b0, -1, 1'b0);
        do_block("empty", 0, 0, 0, 3'b000, 3'b000, 1'b0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            logic [2:0] f, nd;
            for (int n = 0; n < 3; n++) begin
                f[n]  = ($urandom_range(0, 3) == 0);
                nd[n] = ($urandom_range(0, 15) == 0);
            end
            do_block("random", int'($urandom_range(0, 16)), int'($urandom_range(0, 16)),
                     int'($urandom_range(0, 16)), f, nd, 1'($urandom), 1'b1, -1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        do_block("b2b_a", 3, 3, 9, 3'b000, 3'b000, 1'b1, 1'b0, -1, 1'b0);
        do_block("b2b_b", 12, 11, 1, 3'b100, 3'b000, 1'b1, 1'b0, -1, 1'b0);
    endtask

    initial begin
        for (int n = 0; n < 3; n++)
            for (int a = 0; a < 16; a++) mem[n][a] = '0;
        test_reset();
        test_zrle_pick();
        test_all_fail();
        test_tie();
        test_timeout();
        test_abort();
        test_bounds();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
